// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
package dmem_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  localparam int WORD_BYTES  = 4;
  localparam int MAX_LATENCY = 15;

  // Misaligned or beyond the last word of the array.
  function automatic logic addr_err(input logic [31:0] addr, input int unsigned depth);
    return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= 32'(depth));
  endfunction
endpackage

// File: rtl/dmem_array.sv
// Word storage with per-byte write enables and a registered read port.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int IDX_W       = 6
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [WORD_BYTES-1:0] be,
  input  logic [IDX_W-1:0]      idx,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);
  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int b = 0; b < WORD_BYTES; b++)
          if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
      rdata <= mem[idx];
    end
  end
endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready request in, fixed wait states, masked word
// access, valid/ready response out.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);
  localparam int         IDX_W   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int         LAT_CLP = (LATENCY > MAX_LATENCY) ? MAX_LATENCY : LATENCY;
  localparam logic [3:0] LAT_M1  = (LAT_CLP == 0) ? 4'd0 : 4'(LAT_CLP - 1);
  localparam logic       ZERO_LAT = (LAT_CLP == 0);

  state_e      state;
  logic [3:0]  cnt;
  logic        cap_we;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_be;
  logic        rsp_load;
  logic [31:0] arr_rdata;

  logic        accept, acc_en, acc_we, acc_err;
  logic [31:0] acc_addr, acc_wdata;
  logic [3:0]  acc_be;

  assign req_ready = (state == IDLE) && !reset;
  assign busy      = (state != IDLE);
  assign accept    = req_valid && req_ready;

  // Zero wait states: the access happens on the accept edge, straight off the bus.
  assign acc_we    = ZERO_LAT ? req_we    : cap_we;
  assign acc_addr  = ZERO_LAT ? req_addr  : cap_addr;
  assign acc_wdata = ZERO_LAT ? req_wdata : cap_wdata;
  assign acc_be    = ZERO_LAT ? req_be    : cap_be;
  assign acc_err   = addr_err(acc_addr, DEPTH_WORDS);
  assign acc_en    = ZERO_LAT ? accept : ((state == WAIT) && (cnt == 4'd0));

  dmem_array #(.DEPTH_WORDS(DEPTH_WORDS), .IDX_W(IDX_W)) u_array (
    .clk   (clk),
    .en    (acc_en && !acc_err),
    .we    (acc_we),
    .be    (acc_be),
    .idx   (acc_addr[IDX_W+1:2]),
    .wdata (acc_wdata),
    .rdata (arr_rdata)
  );

  // rsp_load is only set for a valid, in-range load, so data is zero otherwise.
  assign rsp_rdata = rsp_load ? arr_rdata : 32'd0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_load  <= 1'b0;
      cap_we    <= 1'b0;
      cap_addr  <= 32'd0;
      cap_wdata <= 32'd0;
      cap_be    <= 4'd0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          cap_we    <= req_we;
          cap_addr  <= req_addr;
          cap_wdata <= req_wdata;
          cap_be    <= req_be;
          if (ZERO_LAT) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= acc_err;
            rsp_load  <= !acc_we && !acc_err;
          end else begin
            cnt   <= LAT_M1;
            state <= WAIT;
          end
        end
        WAIT: if (cnt == 4'd0) begin
          state     <= RESP;
          rsp_valid <= 1'b1;
          rsp_err   <= acc_err;
          rsp_load  <= !acc_we && !acc_err;
        end else begin
          cnt <= cnt - 4'd1;
        end
        RESP: if (rsp_ready) begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          rsp_load  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a LATENCY=2 and a LATENCY=0 instance, each checked
// every cycle against a transaction-level memory model.
module tb_dmem_responder;
  localparam int DEPTH = 64;

  int tests = 0;
  int fails = 0;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic        req_valid [2], req_ready [2], req_we [2];
  logic [31:0] req_addr [2], req_wdata [2], rsp_rdata [2];
  logic [3:0]  req_be [2];
  logic        rsp_valid [2], rsp_ready [2], rsp_err [2], busy [2];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(2)) u0 (
    .clk(clk), .reset(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
    .rsp_err(rsp_err[0]), .busy(busy[0]));

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(0)) u1 (
    .clk(clk), .reset(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
    .rsp_err(rsp_err[1]), .busy(busy[1]));

  // Model: one outstanding transaction per instance; the access lands LATENCY
  // edges after acceptance, and the response is then offered until consumed.
  logic [31:0] mm [2][DEPTH];
  bit          infl [2], done [2], m_we [2], m_err [2];
  int          age [2];
  logic [31:0] m_addr [2], m_wdata [2], m_rdata [2];
  logic [3:0]  m_be [2];

  function automatic int lat_of(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  function automatic bit bad_addr(input logic [31:0] a);
    return (a % 4 != 0) || (a / 4 >= DEPTH);
  endfunction

  task automatic model_access(input int d);
    int idx;
    m_err[d]   = bad_addr(m_addr[d]);
    m_rdata[d] = 32'd0;
    if (!m_err[d]) begin
      idx = int'(m_addr[d] / 4);
      if (m_we[d]) begin
        for (int b = 0; b < 4; b++)
          if (m_be[d][b]) mm[d][idx][8*b +: 8] = m_wdata[d][8*b +: 8];
      end else begin
        m_rdata[d] = mm[d][idx];
      end
    end
    done[d] = 1'b1;
  endtask

  always @(posedge clk or posedge rst) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        infl[d] = 1'b0;
        done[d] = 1'b0;
      end else if (infl[d]) begin
        if (done[d]) begin
          if (rsp_ready[d]) begin infl[d] = 1'b0; done[d] = 1'b0; end
        end else begin
          age[d]++;
          if (age[d] == lat_of(d)) model_access(d);
        end
      end else if (req_valid[d]) begin
        infl[d] = 1'b1; done[d] = 1'b0; age[d] = 0;
        m_we[d] = req_we[d]; m_addr[d] = req_addr[d];
        m_wdata[d] = req_wdata[d]; m_be[d] = req_be[d];
        if (lat_of(d) == 0) model_access(d);
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      logic ev;
      ev = infl[d] && done[d];
      check($sformatf("d%0d req_ready", d), 32'(req_ready[d]), 32'(!rst && !infl[d]));
      check($sformatf("d%0d busy", d),      32'(busy[d]),      32'(infl[d]));
      check($sformatf("d%0d rsp_valid", d), 32'(rsp_valid[d]), 32'(ev));
      check($sformatf("d%0d rsp_rdata", d), rsp_rdata[d],      ev ? m_rdata[d] : 32'd0);
      check($sformatf("d%0d rsp_err", d),   32'(rsp_err[d]),   32'(ev && m_err[d]));
    end
  end

  task automatic issue(input int d, input bit we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] be, output bit ok);
    int n;
    bit acc;
    n = 0; acc = 1'b0;
    req_we[d] = we; req_addr[d] = a; req_wdata[d] = wd; req_be[d] = be; req_valid[d] = 1'b1;
    while (!acc && n < 50) begin
      @(negedge clk); acc = req_ready[d];
      @(posedge clk); #1; n++;
    end
    req_valid[d] = 1'b0;
    ok = acc;
    if (!acc) begin
      tests++; fails++;
      $display("FAIL d%0d accept timeout: req_ready not seen within 50 cycles", d);
    end
  endtask

  // Counts negedges after the accept edge until rsp_valid is seen.
  task automatic wait_rsp(input int d, output logic [31:0] rd, output bit er, output int lat);
    lat = 0;
    do begin @(negedge clk); lat++; end while (!rsp_valid[d] && lat < 50);
    rd = rsp_rdata[d]; er = rsp_err[d];
    if (!rsp_valid[d]) begin
      tests++; fails++;
      $display("FAIL d%0d response timeout: rsp_valid not seen within 50 cycles", d);
    end
  endtask

  task automatic xact(input int d, input bit we, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] be, output logic [31:0] rd, output bit er, output int lat);
    bit ok;
    rsp_ready[d] = 1'b1;
    issue(d, we, a, wd, be, ok);
    rd = 32'd0; er = 1'b0; lat = -1;
    if (ok) begin
      wait_rsp(d, rd, er, lat);
      @(posedge clk); #1;
    end
  endtask

  task automatic rand_run(input int d, input int cycles);
    bit acc;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk); acc = req_valid[d] && req_ready[d];
      @(posedge clk); #1;
      if (acc) req_valid[d] = 1'b0;
      if (!req_valid[d] && ($urandom % 3 == 0)) begin
        case ($urandom % 8)
          0:       req_addr[d] = 32'(($urandom % DEPTH) * 4 + 1 + $urandom % 3);
          1:       req_addr[d] = 32'((DEPTH + $urandom % 64) * 4);
          default: req_addr[d] = 32'(($urandom % 16) * 4);
        endcase
        req_we[d] = 1'($urandom % 2); req_wdata[d] = $urandom;
        req_be[d] = 4'($urandom % 16); req_valid[d] = 1'b1;
      end
      rsp_ready[d] = ($urandom % 4) != 0;
    end
    req_valid[d] = 1'b0; rsp_ready[d] = 1'b1;
    repeat (6) @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, w0;
    bit er, ok;
    int lat, nv;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0; req_we[d] = 1'b0; req_addr[d] = 32'd0;
      req_wdata[d] = 32'd0; req_be[d] = 4'd0; rsp_ready[d] = 1'b1;
    end
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    for (int d = 0; d < 2; d++)
      for (int i = 0; i < DEPTH; i++) xact(d, 1'b1, 32'(i * 4), $urandom, 4'hF, rd, er, lat);

    // LATENCY=2 directed sequence
    xact(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, lat);
    check("L2 store latency", 32'(lat), 32'd3);
    check("L2 store err", 32'(er), 32'd0);
    check("L2 store rdata", rd, 32'd0);
    xact(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
    check("L2 load 0x10", rd, 32'hDEADBEEF);
    xact(0, 1'b1, 32'h10, 32'h000000AA, 4'b0001, rd, er, lat);
    xact(0, 1'b0, 32'h10, 32'h0, 4'hF, rd, er, lat);
    check("byte lane merge", rd, 32'hDEADBEAA);
    check("model pins merge", mm[0][4], 32'hDEADBEAA);
    xact(0, 1'b1, 32'h10, 32'h12345678, 4'b0000, rd, er, lat);
    check("be=0 store err", 32'(er), 32'd0);
    xact(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
    check("be=0 no change", rd, 32'hDEADBEAA);
    xact(0, 1'b0, 32'h12, 32'h0, 4'hF, rd, er, lat);
    check("misaligned err", 32'(er), 32'd1);
    check("misaligned rdata", rd, 32'd0);
    xact(0, 1'b0, 32'h0, 32'h0, 4'hF, w0, er, lat);
    xact(0, 1'b1, 32'h100, 32'hCAFEF00D, 4'hF, rd, er, lat);
    check("out of range err", 32'(er), 32'd1);
    xact(0, 1'b0, 32'h0, 32'h0, 4'hF, rd, er, lat);
    check("no wrap write", rd, mm[0][0]);
    check("word0 stable", rd, w0);

    // Backpressure: response held, stray request pulse ignored
    rsp_ready[0] = 1'b0;
    issue(0, 1'b0, 32'h10, 32'h0, 4'hF, ok);
    wait_rsp(0, rd, er, lat);
    @(posedge clk); #1;
    req_we[0] = 1'b1; req_addr[0] = 32'h10; req_wdata[0] = 32'h0; req_be[0] = 4'hF;
    req_valid[0] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp rsp_valid", 32'(rsp_valid[0]), 32'd1);
      check("bp rsp_rdata", rsp_rdata[0], 32'hDEADBEAA);
      check("bp req_ready", 32'(req_ready[0]), 32'd0);
      @(posedge clk); #1;
      req_valid[0] = 1'b0;
    end
    rsp_ready[0] = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("bp idle after handshake", 32'(busy[0]), 32'd0);
    @(posedge clk); #1;
    xact(0, 1'b0, 32'h10, 32'h0, 4'hF, rd, er, lat);
    check("stray pulse no write", rd, 32'hDEADBEAA);

    // Reset while a store sits in WAIT
    xact(0, 1'b1, 32'h20, 32'h11111111, 4'hF, rd, er, lat);
    issue(0, 1'b1, 32'h20, 32'h22222222, 4'hF, ok);
    rst = 1'b1;
    @(negedge clk);
    check("rst req_ready", 32'(req_ready[0]), 32'd0);
    check("rst busy", 32'(busy[0]), 32'd0);
    check("rst rsp_valid", 32'(rsp_valid[0]), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("req_ready after rst", 32'(req_ready[0]), 32'd1);
    @(posedge clk); #1;
    xact(0, 1'b0, 32'h20, 32'h0, 4'hF, rd, er, lat);
    check("uncommitted store dropped", rd, 32'h11111111);

    // LATENCY=0: single load, then back-to-back with req_valid held
    xact(1, 1'b0, 32'h8, 32'h0, 4'hF, rd, er, lat);
    check("L0 latency", 32'(lat), 32'd1);
    check("L0 load data", rd, mm[1][2]);
    rsp_ready[1] = 1'b1;
    req_we[1] = 1'b0; req_addr[1] = 32'h8; req_valid[1] = 1'b1;
    nv = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); if (rsp_valid[1]) nv++;
    end
    check("L0 b2b responses in 10 cycles", 32'(nv), 32'd5);
    @(posedge clk); #1 req_valid[1] = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    rand_run(0, 600);
    rand_run(1, 600);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
